// File: rtl/segway_pkg.sv
// Shared constants for the Segway motor-drive path.
//   PWM_PERIOD    : clocks per PWM period (11-bit generator)
//   BLANK_CNT     : PWM counts at the start of each period during which
//                   the current comparators are ignored
//   OVR_LIMIT_DEF : default net over-current periods that trip shutdown
//   CNT_W_DEF     : default width of the leaky over-current counter
package segway_pkg;

   localparam int unsigned PWM_PERIOD    = 2048;
   localparam int unsigned BLANK_CNT     = 256;
   localparam int unsigned OVR_LIMIT_DEF = 4;
   localparam int unsigned CNT_W_DEF     = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : asynchronous input
//   q     : synchronized output, two clocks after d
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // meta may go metastable; q gives it a full clock to resolve
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ovr_i_mon.sv
// Over-current monitor downstream of the PWM generator. Decides once per
// PWM period whether the period saw over-current, integrates the verdicts
// in a leaky saturating counter and raises a sticky shutdown request.
//   clk, rst_n    : clock, asynchronous active-low reset
//   PWM_synch     : one-clock strobe on the last count of each PWM period
//   OVR_I_blank_n : high while the comparators may be sampled
//   OVR_I_lft     : left current comparator (asynchronous)
//   OVR_I_rght    : right current comparator (asynchronous)
//   clr_shtdwn    : one-clock clear of shutdown, counter and period flag
//   OVR_I_shtdwn  : sticky shutdown request
//   ovr_evt       : one-clock pulse, the period just ended had over-current
//   ovr_cnt       : leaky counter value
module ovr_i_mon
   import segway_pkg::*;
#(
   parameter int unsigned OVR_LIMIT = OVR_LIMIT_DEF,
   parameter int unsigned CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             PWM_synch,
   input  logic             OVR_I_blank_n,
   input  logic             OVR_I_lft,
   input  logic             OVR_I_rght,
   input  logic             clr_shtdwn,
   output logic             OVR_I_shtdwn,
   output logic             ovr_evt,
   output logic [CNT_W-1:0] ovr_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(OVR_LIMIT);

   logic             lft_s;
   logic             rght_s;
   logic             ovr_s;
   logic             sample;
   logic             verdict;
   logic             period_flag;
   logic             flag_nxt;
   logic             evt_nxt;
   logic             shtdwn_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   sync2 u_sync_lft (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (OVR_I_lft),
      .q     (lft_s)
   );

   sync2 u_sync_rght (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (OVR_I_rght),
      .q     (rght_s)
   );

   // Sampling is gated after synchronization, so pulses delayed into the
   // blank window are dropped as well.
   assign ovr_s   = lft_s | rght_s;
   assign sample  = ovr_s & OVR_I_blank_n;
   // Include this cycle's sample so the final count of a period is judged.
   assign verdict = period_flag | sample;

   // Next-state: period flag, leaky counter, event pulse, shutdown bit
   always_comb begin
      flag_nxt   = period_flag | sample;
      cnt_nxt    = ovr_cnt;
      evt_nxt    = 1'b0;
      shtdwn_nxt = OVR_I_shtdwn;

      if (PWM_synch) begin
         flag_nxt = 1'b0;
         evt_nxt  = verdict;
         if (verdict) begin
            if (ovr_cnt != CNT_MAX) cnt_nxt = ovr_cnt + 1'b1;
         end else begin
            if (ovr_cnt != '0) cnt_nxt = ovr_cnt - 1'b1;
         end
         if (cnt_nxt >= LIMIT) shtdwn_nxt = 1'b1;
      end

      // Clear wins over the period update; the event pulse is left intact.
      if (clr_shtdwn) begin
         flag_nxt   = 1'b0;
         cnt_nxt    = '0;
         shtdwn_nxt = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_flag  <= 1'b0;
         ovr_cnt      <= '0;
         ovr_evt      <= 1'b0;
         OVR_I_shtdwn <= 1'b0;
      end else begin
         period_flag  <= flag_nxt;
         ovr_cnt      <= cnt_nxt;
         ovr_evt      <= evt_nxt;
         OVR_I_shtdwn <= shtdwn_nxt;
      end
   end

endmodule

// File: tb/tb_ovr_i_mon.sv
// Self-checking bench for ovr_i_mon: table of per-period stimulus with
// expected results, a mid-period asynchronous reset sequence, and random
// periods checked against an interval-based reference model.
module tb_ovr_i_mon;

   localparam int PERIOD = 2048;
   localparam int BLANK  = 256;
   localparam int LIMIT  = 4;
   localparam int CMAX   = 15;
   localparam int SYNC_D = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       PWM_synch;
   logic       OVR_I_blank_n;
   logic       OVR_I_lft;
   logic       OVR_I_rght;
   logic       clr_shtdwn;
   logic       OVR_I_shtdwn;
   logic       ovr_evt;
   logic [3:0] ovr_cnt;

   always #5 clk = ~clk;

   ovr_i_mon #(.OVR_LIMIT(LIMIT), .CNT_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .PWM_synch     (PWM_synch),
      .OVR_I_blank_n (OVR_I_blank_n),
      .OVR_I_lft     (OVR_I_lft),
      .OVR_I_rght    (OVR_I_rght),
      .clr_shtdwn    (clr_shtdwn),
      .OVR_I_shtdwn  (OVR_I_shtdwn),
      .ovr_evt       (ovr_evt),
      .ovr_cnt       (ovr_cnt)
   );

   // One period of stimulus: a single comparator pulse [st, st+len) in PWM
   // counts (len=0: none), plus expected results after the period closes.
   // tid 9 marks the hand-written mid-period reset sequence.
   typedef struct {
      int tid;
      int st;
      int len;
      bit rght;
      bit clr;
      bit e_evt;
      int e_cnt;
      bit e_sh;
   } vec_t;

   vec_t tbl[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   m_cnt   = 0;
   bit   m_sh    = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic add(input int tid, input int st, input int len, input bit rght,
                      input bit clr, input bit e_evt, input int e_cnt, input bit e_sh);
      vec_t v;
      v.tid = tid; v.st = st; v.len = len; v.rght = rght; v.clr = clr;
      v.e_evt = e_evt; v.e_cnt = e_cnt; v.e_sh = e_sh;
      tbl.push_back(v);
   endtask

   // Reference: a comparator level seen at count c reaches the sampler at
   // count c+2; the period has over-current if any such landing count is
   // inside the unblanked part of the same period.
   function automatic bit period_verdict(input int st, input int len);
      int first;
      int last;
      if (len == 0) return 1'b0;
      first = st + SYNC_D;
      last  = st + len - 1 + SYNC_D;
      return (last >= BLANK) && (first <= PERIOD - 1);
   endfunction

   task automatic model_close(input bit v, input bit clr);
      if (clr) begin
         m_cnt = 0;
         m_sh  = 1'b0;
      end else begin
         m_cnt = v ? ((m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1)
                   : ((m_cnt - 1 < 0) ? 0 : m_cnt - 1);
         if (m_cnt >= LIMIT) m_sh = 1'b1;
      end
   endtask

   task automatic drive_count(input int k, input bit lvl, input bit rght, input bit clr);
      PWM_synch     = (k == PERIOD - 1);
      OVR_I_blank_n = (k >= BLANK);
      OVR_I_lft     = lvl & ~rght;
      OVR_I_rght    = lvl & rght;
      clr_shtdwn    = clr & (k == PERIOD - 1);
   endtask

   task automatic run_period(input int st, input int len, input bit rght, input bit clr,
                             output int evt_a, output int cnt_a, output int sh_a,
                             output int extra);
      extra = 0;
      for (int k = 0; k < PERIOD; k++) begin
         drive_count(k, (len > 0) && (k >= st) && (k < st + len), rght, clr);
         @(posedge clk);
         #1;
         if (k != PERIOD - 1 && ovr_evt) extra++;
      end
      evt_a = int'(ovr_evt);
      cnt_a = int'(ovr_cnt);
      sh_a  = int'(OVR_I_shtdwn);
      drive_count(0, 1'b0, 1'b0, 1'b0);
      model_close(period_verdict(st, len), clr);
   endtask

   // Half a period of continuing over-current, then reset away from an edge.
   task automatic reset_mid_period();
      for (int k = 0; k < PERIOD / 2; k++) begin
         drive_count(k, 1'b1, 1'b0, 1'b0);
         @(posedge clk);
         #1;
      end
      chk("pre_rst_shtdwn", int'(OVR_I_shtdwn), 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_cnt", int'(ovr_cnt), 0);
      chk("async_rst_shtdwn", int'(OVR_I_shtdwn), 0);
      chk("async_rst_evt", int'(ovr_evt), 0);
      drive_count(0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_cnt = 0;
      m_sh  = 1'b0;
   endtask

   initial begin
      int evt_a;
      int cnt_a;
      int sh_a;
      int extra;
      int st;
      int len;
      bit v;
      bit rg;
      bit cl;

      // 1: idle
      repeat (3) add(1, 0, 0, 0, 0, 0, 0, 0);
      // 2: fully blanked activity
      repeat (10) add(2, 0, 201, 0, 0, 0, 0, 0);
      // 3: four over-current periods trip shutdown
      add(3, 1000, 5, 1, 0, 1, 1, 0);
      add(3, 1000, 5, 1, 0, 1, 2, 0);
      add(3, 1000, 5, 1, 0, 1, 3, 0);
      add(3, 1000, 5, 1, 0, 1, 4, 1);
      // 6: clear with the strobe, then re-trip after four periods
      add(6, 1000, 5, 1, 1, 1, 0, 0);
      add(6, 1000, 5, 1, 0, 1, 1, 0);
      add(6, 1000, 5, 1, 0, 1, 2, 0);
      add(6, 1000, 5, 1, 0, 1, 3, 0);
      add(6, 1000, 5, 1, 0, 1, 4, 1);
      add(9, 0, 0, 0, 0, 0, 0, 0);
      // 4: leaky counting
      add(4, 1000, 5, 0, 0, 1, 1, 0);
      add(4, 0, 0, 0, 0, 0, 0, 0);
      add(4, 1000, 5, 0, 0, 1, 1, 0);
      add(4, 0, 0, 0, 0, 0, 0, 0);
      add(4, 1200, 3, 0, 0, 1, 1, 0);
      add(4, 1200, 3, 1, 0, 1, 2, 0);
      add(4, 1200, 3, 0, 0, 1, 3, 0);
      add(4, 0, 0, 0, 0, 0, 2, 0);
      add(4, 300, 1, 1, 0, 1, 3, 0);
      add(4, 300, 1, 0, 0, 1, 4, 1);
      add(4, 0, 0, 0, 1, 0, 0, 0);
      // 5: boundary pulses at both ends of the sampling window
      add(5, 2045, 1, 0, 0, 1, 1, 0);
      add(5, 2046, 1, 1, 0, 0, 0, 0);
      add(5, 253, 1, 0, 0, 0, 0, 0);
      add(5, 254, 1, 1, 0, 1, 1, 0);
      add(5, 0, 0, 0, 0, 0, 0, 0);

      rst_n = 1'b0;
      drive_count(0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("reset_cnt", int'(ovr_cnt), 0);
      chk("reset_shtdwn", int'(OVR_I_shtdwn), 0);
      chk("reset_evt", int'(ovr_evt), 0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         if (tbl[i].tid == 9) begin
            reset_mid_period();
         end else begin
            run_period(tbl[i].st, tbl[i].len, tbl[i].rght, tbl[i].clr,
                       evt_a, cnt_a, sh_a, extra);
            chk($sformatf("t%0d_row%0d_evt", tbl[i].tid, i), evt_a, int'(tbl[i].e_evt));
            chk($sformatf("t%0d_row%0d_cnt", tbl[i].tid, i), cnt_a, tbl[i].e_cnt);
            chk($sformatf("t%0d_row%0d_shtdwn", tbl[i].tid, i), sh_a, int'(tbl[i].e_sh));
            chk($sformatf("t%0d_row%0d_stray_evt", tbl[i].tid, i), extra, 0);
         end
      end

      for (int r = 0; r < 6; r++) begin
         st  = int'($urandom_range(0, PERIOD - 1));
         len = int'($urandom_range(1, 8));
         if (st + len > PERIOD) len = PERIOD - st;
         rg  = 1'($urandom_range(0, 1));
         cl  = ($urandom_range(0, 3) == 0);
         v   = period_verdict(st, len);
         run_period(st, len, rg, cl, evt_a, cnt_a, sh_a, extra);
         chk($sformatf("rand%0d_st%0d_evt", r, st), evt_a, int'(v));
         chk($sformatf("rand%0d_st%0d_cnt", r, st), cnt_a, m_cnt);
         chk($sformatf("rand%0d_st%0d_shtdwn", r, st), sh_a, int'(m_sh));
         chk($sformatf("rand%0d_st%0d_stray_evt", r, st), extra, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
